// File: rtl/blink_sequencer.sv
// Pattern-driven blink sequencer: plays a latched bit pattern on D0, holding
// each bit for DIV cycles, once (with a DONE pulse) or looping until STOP.
module blink_sequencer #(
  parameter int unsigned DIV   = 10,
  parameter int unsigned PAT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       LOOP,
  input  logic [PAT_W-1:0]           PATTERN,
  output logic                       D0,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [$clog2(PAT_W)-1:0]   BIT_IDX
);

  localparam int unsigned IDX_W = $clog2(PAT_W);
  // DIV=1 still gets a 1-bit counter; it simply never leaves 0.
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PAT_W-1:0]   shadow;
  logic               loop_q;
  logic [IDX_W-1:0]   idx_nxt;

  assign idx_nxt = BIT_IDX + IDX_W'(1);

  // Sequencer state, divider and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      loop_q  <= 1'b0;
      D0      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      BIT_IDX <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START && !STOP) begin
            shadow  <= PATTERN;
            loop_q  <= LOOP;
            cnt     <= '0;
            BIT_IDX <= '0;
            D0      <= PATTERN[0];
            BUSY    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (STOP) begin
            state   <= IDLE;
            cnt     <= '0;
            D0      <= 1'b0;
            BUSY    <= 1'b0;
            BIT_IDX <= '0;
          end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (BIT_IDX != IDX_LAST) begin
              BIT_IDX <= idx_nxt;
              D0      <= shadow[idx_nxt];
            end else if (loop_q) begin
              BIT_IDX <= '0;
              D0      <= shadow[0];
            end else begin
              state   <= IDLE;
              D0      <= 1'b0;
              BUSY    <= 1'b0;
              BIT_IDX <= '0;
              DONE    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
